// File: rtl/vram_pkg.sv
// Shared types and helpers for the dual-port VRAM model.
// Holds the transfer-type enum, the address-width helper and the all-ones mask.
package vram_pkg;

   typedef enum logic [1:0] {
      XFER_NONE,
      XFER_FULL,
      XFER_SPLIT
   } xfer_t;

   localparam int MAX_DW = 64;
   localparam logic [MAX_DW-1:0] MASK_ONES = '1;

   // Width of the multiplexed address bus: wider of row and column.
   function automatic int addr_w(input int r, input int c);
      return (r > c) ? r : c;
   endfunction

endpackage

// File: rtl/vram_ser_reg.sv
// Serial access port: shift register, tap counter, split halves and QSF.
// Ports: MCLK, reset, xfer (transfer type), sc_rise, col, row_data -> SD_o, QSF.
module vram_ser_reg
   import vram_pkg::*;
#(
   parameter  int DW       = 8,
   parameter  int COL_BITS = 8,
   localparam int NCOL     = 2 ** COL_BITS
) (
   input  logic                     MCLK,
   input  logic                     reset,
   input  xfer_t                    xfer,
   input  logic                     sc_rise,
   input  logic [COL_BITS-1:0]      col,
   input  logic [NCOL-1:0][DW-1:0]  row_data,
   output logic [DW-1:0]            SD_o,
   output logic                     QSF
);

   localparam int HALF = NCOL / 2;

   logic [DW-1:0]       ser [NCOL];
   logic [COL_BITS-1:0] tap;
   logic [COL_BITS-2:0] pend;
   logic                smode;

   assign QSF = tap[COL_BITS-1];

   // Contents survive reset; a split load refills only the idle half.
   always_ff @(posedge MCLK) begin
      for (int i = 0; i < NCOL; i++) begin
         if (xfer == XFER_FULL)
            ser[i] <= row_data[i];
         else if (xfer == XFER_SPLIT && ((i >= HALF) != QSF))
            ser[i] <= row_data[i];
      end
   end

   always_ff @(posedge MCLK) begin
      if (reset) begin
         tap   <= '0;
         pend  <= '0;
         smode <= 1'b0;
         SD_o  <= '0;
      end else if (xfer == XFER_FULL) begin
         // A full load repositions the tap; a coincident SC edge is lost.
         tap   <= col;
         smode <= 1'b0;
      end else begin
         if (xfer == XFER_SPLIT) begin
            pend  <= col[COL_BITS-2:0];
            smode <= 1'b1;
         end
         if (sc_rise) begin
            SD_o <= ser[tap];
            if (smode && (&tap[COL_BITS-2:0]))
               tap <= {~tap[COL_BITS-1], pend};
            else
               tap <= tap + 1'b1;
         end
      end
   end

endmodule

// File: rtl/vram_split.sv
// Dual-port video DRAM: random port (RAS/CAS/WE/OE) plus serial port (SC/SE).
// Ports: MCLK, reset, strobes, AD, RD_i -> RD_o, RD_d, SD_o, SD_d, QSF.
module vram_split
   import vram_pkg::*;
#(
   parameter  int DW       = 8,
   parameter  int ROW_BITS = 8,
   parameter  int COL_BITS = 8,
   parameter  int WPB_EN   = 1,
   parameter  int SPLIT_EN = 1,
   localparam int AW       = addr_w(ROW_BITS, COL_BITS)
) (
   input  logic            MCLK,
   input  logic            reset,
   input  logic            RAS,
   input  logic            CAS,
   input  logic            WE,
   input  logic            OE,
   input  logic            DSF,
   input  logic            SC,
   input  logic            SE,
   input  logic [AW-1:0]   AD,
   input  logic [DW-1:0]   RD_i,
   output logic [DW-1:0]   RD_o,
   output logic            RD_d,
   output logic [DW-1:0]   SD_o,
   output logic            SD_d,
   output logic            QSF
);

   localparam int NROW = 2 ** ROW_BITS;
   localparam int NCOL = 2 ** COL_BITS;
   localparam logic [DW-1:0] ONES = MASK_ONES[DW-1:0];

   logic [NCOL-1:0][DW-1:0] mem [NROW];

   logic                ras_q, cas_q, oe_q, sc_q;
   logic                cyc, dt, split, valid;
   logic [ROW_BITS-1:0] row;
   logic [COL_BITS-1:0] col;
   logic [DW-1:0]       mask;
   xfer_t               xfer;

   logic cas_act, ras_fall, cas_rise, cas_hold;
   logic oe_rise, sc_rise, do_wr, do_rd;

   assign cas_act  = ~RAS & ~CAS;
   assign ras_fall = ras_q & ~RAS;
   assign cas_rise = cas_act & ~cas_q;
   // cyc gates access so a cycle cut by reset cannot resume mid-way.
   assign cas_hold = cas_act & cas_q & cyc;
   assign oe_rise  = OE & ~oe_q;
   assign sc_rise  = SC & ~sc_q;
   assign do_wr    = cas_hold & ~WE & ~dt;
   assign do_rd    = cas_hold & ~OE & ~dt;

   assign RD_d = ~valid;
   assign SD_d = SE;

   always_comb begin
      xfer = XFER_NONE;
      if (oe_rise && dt)
         xfer = split ? XFER_SPLIT : XFER_FULL;
   end

   always_ff @(posedge MCLK) begin
      if (do_wr)
         mem[row][col] <= (mem[row][col] & ~mask) | (RD_i & mask);
   end

   always_ff @(posedge MCLK) begin
      if (reset) begin
         // ras_q low forces RAS to return high before the next fall.
         ras_q <= 1'b0;
         cas_q <= 1'b0;
         oe_q  <= 1'b1;
         sc_q  <= 1'b1;
         cyc   <= 1'b0;
         dt    <= 1'b0;
         split <= 1'b0;
         valid <= 1'b0;
         row   <= '0;
         col   <= '0;
         mask  <= ONES;
         RD_o  <= '0;
      end else begin
         ras_q <= RAS;
         cas_q <= cas_act;
         oe_q  <= OE;
         sc_q  <= SC;
         if (RAS)
            cyc <= 1'b0;
         if (ras_fall) begin
            cyc   <= 1'b1;
            row   <= AD[ROW_BITS-1:0];
            dt    <= ~OE;
            split <= ~OE & DSF & (SPLIT_EN != 0);
            mask  <= (~WE && (WPB_EN != 0)) ? RD_i : ONES;
         end
         if (cas_rise)
            col <= AD[COL_BITS-1:0];
         if (do_rd) begin
            RD_o  <= mem[row][col];
            valid <= 1'b1;
         end else if (CAS || OE) begin
            valid <= 1'b0;
         end
      end
   end

   vram_ser_reg #(
      .DW       (DW),
      .COL_BITS (COL_BITS)
   ) u_ser (
      .MCLK     (MCLK),
      .reset    (reset),
      .xfer     (xfer),
      .sc_rise  (sc_rise),
      .col      (col),
      .row_data (mem[row]),
      .SD_o     (SD_o),
      .QSF      (QSF)
   );

endmodule

// File: tb/tb_vram_split.sv
// Scoreboard bench for vram_split: random-port and serial-port directed tests.
// Stimulus queues expected data; a negedge monitor pops on each presentation.
module tb_vram_split;

   logic       MCLK = 1'b0;
   logic       reset, RAS, CAS, WE, OE, DSF, SC, SE;
   logic [7:0] AD, RD_i;
   logic [7:0] RD_o, SD_o;
   logic       RD_d, SD_d, QSF;

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] rd_q [$];
   logic [7:0] sd_q [$];
   logic       rd_d_m = 1'b1;
   logic       sc_m = 1'b0;

   vram_split dut (
      .MCLK (MCLK),
      .reset(reset),
      .RAS  (RAS),
      .CAS  (CAS),
      .WE   (WE),
      .OE   (OE),
      .DSF  (DSF),
      .SC   (SC),
      .SE   (SE),
      .AD   (AD),
      .RD_i (RD_i),
      .RD_o (RD_o),
      .RD_d (RD_d),
      .SD_o (SD_o),
      .SD_d (SD_d),
      .QSF  (QSF)
   );

   always #5 MCLK = ~MCLK;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Monitor: RD_d falling presents RD_o, an SC rise presents SD_o.
   always @(negedge MCLK) begin
      if (!reset) begin
         if (rd_d_m && !RD_d) begin
            if (rd_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL rd_unexpected: got %0h expected none", RD_o);
            end else begin
               chk("rd_data", RD_o, rd_q.pop_front());
            end
         end
         if (SC && !sc_m) begin
            if (sd_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sd_unexpected: got %0h expected none", SD_o);
            end else begin
               chk("sd_data", SD_o, sd_q.pop_front());
            end
         end
      end
      rd_d_m = RD_d;
      sc_m   = SC;
   end

   task automatic step(input int n);
      repeat (n) @(negedge MCLK);
      #1;
   endtask

   task automatic ras_open(input logic [7:0] r, input logic we_low,
                           input logic [7:0] m);
      AD   = r;
      RD_i = m;
      WE   = ~we_low;
      RAS  = 1'b0;
      step(1);
      WE   = 1'b1;
   endtask

   task automatic ras_close();
      RAS = 1'b1;
      CAS = 1'b1;
      OE  = 1'b1;
      WE  = 1'b1;
      step(1);
   endtask

   task automatic wr(input logic [7:0] c, input logic [7:0] d);
      AD   = c;
      RD_i = d;
      WE   = 1'b0;
      CAS  = 1'b0;
      step(2);
      CAS  = 1'b1;
      WE   = 1'b1;
      step(1);
   endtask

   task automatic rd(input logic [7:0] c, input logic [7:0] exp);
      AD  = c;
      OE  = 1'b0;
      CAS = 1'b0;
      rd_q.push_back(exp);
      step(1);
      chk("rd_d_first_edge", RD_d, 1'b1);
      step(1);
      chk("rd_d_second_edge", RD_d, 1'b0);
      CAS = 1'b1;
      OE  = 1'b1;
      step(1);
      chk("rd_d_after_cas", RD_d, 1'b1);
   endtask

   task automatic xfer(input logic [7:0] r, input logic dsf,
                       input logic [7:0] c, input logic with_sc,
                       input logic [7:0] exp);
      AD  = r;
      OE  = 1'b0;
      DSF = dsf;
      RAS = 1'b0;
      step(1);
      AD  = c;
      CAS = 1'b0;
      step(1);
      OE  = 1'b1;
      if (with_sc) begin
         SC = 1'b1;
         sd_q.push_back(exp);
      end
      step(1);
      CAS = 1'b1;
      RAS = 1'b1;
      SC  = 1'b0;
      DSF = 1'b0;
      step(1);
   endtask

   task automatic sc_pulse(input logic [7:0] exp);
      SC = 1'b1;
      sd_q.push_back(exp);
      step(1);
      SC = 1'b0;
      step(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      RAS = 1'b1; CAS = 1'b1; WE = 1'b1; OE = 1'b1;
      DSF = 1'b0; SC = 1'b0; SE = 1'b0;
      AD = '0; RD_i = '0;
      step(3);
      chk("rst_rd_o", RD_o, 8'h00);
      chk("rst_rd_d", RD_d, 1'b1);
      chk("rst_sd_o", SD_o, 8'h00);
      chk("rst_qsf", QSF, 1'b0);
      chk("sd_d_follows_se", SD_d, 1'b0);
      reset = 1'b0;
      step(2);

      // Page-mode write then read on row 3.
      ras_open(8'd3, 1'b0, 8'h00);
      wr(8'd7, 8'hA5);
      wr(8'd6, 8'h5A);
      rd(8'd7, 8'hA5);
      rd(8'd6, 8'h5A);
      ras_close();

      // Write-per-bit mask 0x0F.
      ras_open(8'd3, 1'b0, 8'h00);
      wr(8'd8, 8'h00);
      ras_close();
      ras_open(8'd3, 1'b1, 8'h0F);
      wr(8'd8, 8'hFF);
      ras_close();
      ras_open(8'd3, 1'b0, 8'h00);
      rd(8'd8, 8'h0F);
      ras_close();

      // Serial source data.
      ras_open(8'd5, 1'b0, 8'h00);
      wr(8'hFE, 8'h11);
      wr(8'hFF, 8'h22);
      wr(8'h00, 8'h33);
      wr(8'h7E, 8'h44);
      wr(8'h7F, 8'h55);
      ras_close();
      ras_open(8'd9, 1'b0, 8'h00);
      wr(8'h90, 8'h66);
      ras_close();

      // Full transfer with wrap.
      xfer(8'd5, 1'b0, 8'hFE, 1'b0, 8'h00);
      chk("qsf_full_fe", QSF, 1'b1);
      sc_pulse(8'h11);
      sc_pulse(8'h22);
      sc_pulse(8'h33);
      chk("qsf_after_wrap", QSF, 1'b0);

      // Split transfer coinciding with a shift, then half swap.
      xfer(8'd5, 1'b0, 8'h7E, 1'b0, 8'h00);
      chk("qsf_before_split", QSF, 1'b0);
      xfer(8'd9, 1'b1, 8'h10, 1'b1, 8'h44);
      sc_pulse(8'h55);
      chk("qsf_after_swap", QSF, 1'b1);
      sc_pulse(8'h66);

      // Full transfer drops a coincident SC edge.
      xfer(8'd5, 1'b0, 8'hFF, 1'b1, 8'h66);
      chk("qsf_full_ff", QSF, 1'b1);
      sc_pulse(8'h22);
      chk("qsf_full_wrap", QSF, 1'b0);

      // Reset in the middle of a read burst.
      ras_open(8'd3, 1'b0, 8'h00);
      AD  = 8'd7;
      OE  = 1'b0;
      CAS = 1'b0;
      rd_q.push_back(8'hA5);
      step(2);
      reset = 1'b1;
      step(1);
      chk("mid_rst_rd_d", RD_d, 1'b1);
      chk("mid_rst_sd_o", SD_o, 8'h00);
      chk("mid_rst_qsf", QSF, 1'b0);
      reset = 1'b0;
      step(2);
      chk("aborted_rd_d", RD_d, 1'b1);
      ras_close();
      sc_pulse(8'h33);
      ras_open(8'd3, 1'b0, 8'h00);
      rd(8'd7, 8'hA5);
      rd(8'd8, 8'h0F);
      ras_close();

      step(4);
      chk("rd_q_drained", rd_q.size(), 0);
      chk("sd_q_drained", sd_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
